// File: rtl/mem_map_pkg.sv
// Shared memory map, requester indices and arbiter FSM encoding.
// The memory block uses the same address constants.
package mem_map_pkg;

    localparam int          N_REQ       = 3;
    localparam logic [15:0] DATA_TOP    = 16'd16383;
    localparam logic [15:0] SCREEN_BASE = 16'd16384;
    localparam logic [15:0] KBD_ADDR    = 16'd24576;

    localparam logic [1:0]  REQ_CPU = 2'd0;
    localparam logic [1:0]  REQ_VID = 2'd1;
    localparam logic [1:0]  REQ_KBD = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    // Per-requester region rules; anything not listed is rejected.
    function automatic logic is_legal(input logic [1:0]  idx,
                                      input logic        wr,
                                      input logic [15:0] a);
        logic ok;
        ok = 1'b0;
        case (idx)
            REQ_CPU: ok = (a <= KBD_ADDR) && !(wr && (a == KBD_ADDR));
            REQ_VID: ok = !wr && (a >= SCREEN_BASE) && (a < KBD_ADDR);
            REQ_KBD: ok = wr && (a == KBD_ADDR);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the memory arbiter.
interface mem_arbiter_if;

    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic [15:0] wdata2;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;

    // Arbiter side.
    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_out,
        output gnt, done, err, rdata, mem_address, mem_in, mem_load
    );

    // Requesters and memory side.
    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_out,
        input  gnt, done, err, rdata, mem_address, mem_in, mem_load
    );

endinterface

// File: rtl/mem_arbiter_rr_pick3.sv
// Combinational three-way round-robin selector: ptr names the requester
// with highest priority, the rest follow in ascending order modulo 3.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    // First requesting index starting from ptr wins.
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd0: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
            2'd1: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            default: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-port main memory. A grant occupies
// one ACCESS cycle, during which the memory acts on the falling edge;
// completion (done/err/rdata) follows in the next cycle.
module mem_arbiter
    import mem_map_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    arb_state_t  state_q, state_d;
    logic [1:0]  ptr_q;
    logic        wr_q;
    logic        bad_q;
    logic [2:0]  pick;
    logic [1:0]  win_idx;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_we;
    logic        sel_legal;

    rr_pick3 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (pick)
    );

    // Mux the winning requester's address, data and direction, and decode legality.
    always_comb begin
        win_idx   = REQ_CPU;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        sel_we    = bus.we[0];
        if (pick[1]) begin
            win_idx   = REQ_VID;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
            sel_we    = bus.we[1];
        end else if (pick[2]) begin
            win_idx   = REQ_KBD;
            sel_addr  = bus.addr2;
            sel_wdata = bus.wdata2;
            sel_we    = bus.we[2];
        end
        sel_legal = is_legal(win_idx, sel_we, sel_addr);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: IDLE leaves on any request, ACCESS always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|bus.req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Grant registration in IDLE, completion and read capture at the end of ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q           <= REQ_CPU;
            wr_q            <= 1'b0;
            bad_q           <= 1'b0;
            bus.gnt         <= 3'b000;
            bus.done        <= 3'b000;
            bus.err         <= 1'b0;
            bus.rdata       <= 16'h0000;
            bus.mem_address <= 16'h0000;
            bus.mem_in      <= 16'h0000;
            bus.mem_load    <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            bus.done     <= 3'b000;
            bus.err      <= 1'b0;
            bus.gnt      <= pick;
            bus.mem_load <= 1'b0;
            if (|bus.req) begin
                bus.mem_address <= sel_addr;
                bus.mem_in      <= sel_wdata;
                // Rejected requests never reach the memory as a write.
                bus.mem_load    <= sel_we & sel_legal;
                wr_q            <= sel_we;
                bad_q           <= ~sel_legal;
                ptr_q           <= (win_idx == REQ_KBD) ? REQ_CPU : win_idx + 2'd1;
            end
        end else begin
            bus.gnt      <= 3'b000;
            bus.done     <= bus.gnt;
            bus.err      <= bad_q;
            bus.mem_load <= 1'b0;
            if (!wr_q && !bad_q) bus.rdata <= bus.mem_out;
        end
    end

endmodule
